// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: groups the processor-facing interrupt signals of irq_ctrl.
//   irq        4  external request lines, bit 0 has the highest priority
//   int_ack    1  processor took the interrupt (one-cycle pulse)
//   int_done   1  processor returned from the handler (one-cycle pulse)
//   mask_we    1  mask write strobe
//   mask_wd    4  mask write data, 1 enables a source
//   interrupt  1  request to the processor
//   vector    32  handler address for active_id
//   active_id  2  source currently requested or in service
//   pending    4  captured, unserviced requests
//   mask       4  current enable mask
//   busy       1  controller is not idle
// Modports: master = processor side, slave = irq_ctrl side.
interface irq_ctrl_if;
    logic [3:0]  irq;
    logic        int_ack;
    logic        int_done;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic        interrupt;
    logic [31:0] vector;
    logic [1:0]  active_id;
    logic [3:0]  pending;
    logic [3:0]  mask;
    logic        busy;

    modport master (
        output irq, int_ack, int_done, mask_we, mask_wd,
        input  interrupt, vector, active_id, pending, mask, busy
    );

    modport slave (
        input  irq, int_ack, int_done, mask_we, mask_wd,
        output interrupt, vector, active_id, pending, mask, busy
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: 4-source prioritised interrupt controller with a maskable pending register
// and an IDLE -> REQ -> SERVICE handshake with the processor.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    irq_ctrl_if.slave (irq, int_ack, int_done, mask_we, mask_wd in;
//          interrupt, vector, active_id, pending, mask, busy out)
// Parameters: VEC_BASE (handler of source 0), VEC_STRIDE (byte spacing of handlers).
// Build option: define IRQ_EDGE_DETECT_EN for rising-edge capture of irq; otherwise
// capture is level-triggered.
module irq_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h000000C0,
    parameter logic [31:0] VEC_STRIDE = 32'h00000010
) (
    input logic       clk,
    input logic       reset,
    irq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e     state_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] mask_q;
    logic [1:0] active_id_q;
    logic       interrupt_q;
    logic       busy_q;

    logic [3:0] set_vec;
    logic [3:0] clr_vec;
    logic [3:0] elig;
    logic [1:0] winner;

`ifdef IRQ_EDGE_DETECT_EN
    logic [3:0] irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= bus.irq;
        end
    end

    // A held line raises only one request.
    assign set_vec = bus.irq & ~irq_q;
`else
    assign set_vec = bus.irq;
`endif

    always_comb begin
        clr_vec = '0;
        if (state_q == StReq && bus.int_ack) begin
            clr_vec[active_id_q] = 1'b1;
        end
        // Set after clear so a simultaneous new request is not lost.
        pending_d = (pending_q & ~clr_vec) | set_vec;
        elig      = pending_q & mask_q;
        winner    = '0;
        for (int i = 3; i >= 0; i--) begin
            if (elig[i]) begin
                winner = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            mask_q      <= '0;
            active_id_q <= '0;
            interrupt_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (bus.mask_we) begin
                mask_q <= bus.mask_wd;
            end
            case (state_q)
                StIdle: begin
                    if (|elig) begin
                        state_q     <= StReq;
                        active_id_q <= winner;
                        interrupt_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                // active_id stays frozen until the processor acknowledges.
                StReq: begin
                    if (bus.int_ack) begin
                        state_q     <= StService;
                        interrupt_q <= 1'b0;
                    end
                end
                StService: begin
                    if (bus.int_done) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    interrupt_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interrupt = interrupt_q;
    assign bus.busy      = busy_q;
    assign bus.active_id = active_id_q;
    assign bus.pending   = pending_q;
    assign bus.mask      = mask_q;
    assign bus.vector    = VEC_BASE + 32'(active_id_q) * VEC_STRIDE;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios followed by random traffic, all checked every cycle
// against a behavioural model of the controller.
module tb_irq_ctrl;
    logic clk;
    logic reset;
    irq_ctrl_if bus ();

    irq_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Model: mode 0 = idle, 1 = requesting, 2 = in service.
    int       m_mode;
    int       m_id;
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    bit [3:0] m_prev_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit [3:0] irq_v, input bit ack,
                              input bit done, input bit mwe, input bit [3:0] mwd);
        bit [3:0] captured;
        bit [3:0] eligible;
        bit [3:0] served;
        if (rst) begin
            m_mode = 0; m_id = 0; m_pend = 0; m_mask = 0; m_prev_irq = 0;
            return;
        end
`ifdef IRQ_EDGE_DETECT_EN
        captured = irq_v & ~m_prev_irq;
`else
        captured = irq_v;
`endif
        served   = (m_mode == 1 && ack) ? 4'(1 << m_id) : 4'b0;
        eligible = m_pend & m_mask;
        if (m_mode == 0) begin
            if (eligible != 0) begin
                m_mode = 1;
                for (int i = 0; i < 4; i++) begin
                    if (eligible[i]) begin
                        m_id = i;
                        break;
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (ack) m_mode = 2;
        end else begin
            if (done) m_mode = 0;
        end
        m_pend     = (m_pend & ~served) | captured;
        if (mwe) m_mask = mwd;
        m_prev_irq = irq_v;
    endtask

    task automatic cyc(input bit rst, input bit [3:0] irq_v, input bit ack, input bit done,
                       input bit mwe, input bit [3:0] mwd);
        reset        = rst;
        bus.irq      = irq_v;
        bus.int_ack  = ack;
        bus.int_done = done;
        bus.mask_we  = mwe;
        bus.mask_wd  = mwd;
        @(posedge clk);
        model_step(rst, irq_v, ack, done, mwe, mwd);
        #1;
        vectors++;
        chk("interrupt", 32'(bus.interrupt), 32'(m_mode == 1));
        chk("busy",      32'(bus.busy),      32'(m_mode != 0));
        chk("active_id", 32'(bus.active_id), 32'(m_id));
        chk("vector",    bus.vector,         32'h000000C0 + 32'(m_id) * 32'h10);
        chk("pending",   32'(bus.pending),   32'(m_pend));
        chk("mask",      32'(bus.mask),      32'(m_mask));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_mode = 0; m_id = 0; m_pend = 0; m_mask = 0; m_prev_irq = 0;

        // Reset state.
        cyc(1, 4'h0, 0, 0, 0, 4'h0);
        cyc(1, 4'h0, 0, 0, 0, 4'h0);
        chk("rst_vector", bus.vector, 32'h000000C0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // Single source 2: one-edge latency, vector 0xE0.
        cyc(0, 4'h0, 0, 0, 1, 4'hF);
        cyc(0, 4'b0100, 0, 0, 0, 4'h0);
        chk("lat_early", 32'(bus.interrupt), 32'd0);
        cyc(0, 4'h0, 0, 0, 0, 4'h0);
        chk("lat_irq", 32'(bus.interrupt), 32'd1);
        chk("lat_vec", bus.vector, 32'h000000E0);
        cyc(0, 4'h0, 1, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 1, 0, 4'h0);

        // Simultaneous 1 and 3: priority then follow-up.
        cyc(0, 4'b1010, 0, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 0, 0, 4'h0);
        chk("prio_vec1", bus.vector, 32'h000000D0);
        cyc(0, 4'h0, 1, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 1, 0, 4'h0);
        chk("prio_idle", 32'(bus.busy), 32'd0);
        cyc(0, 4'h0, 0, 0, 0, 4'h0);
        chk("prio_vec3", bus.vector, 32'h000000F0);
        cyc(0, 4'h0, 1, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 1, 0, 4'h0);

        // Higher-priority arrival while requesting does not preempt.
        cyc(0, 4'b0100, 0, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 0, 0, 4'h0);
        cyc(0, 4'b0001, 0, 0, 0, 4'h0);
        chk("frozen_id", 32'(bus.active_id), 32'd2);
        chk("frozen_pend", 32'(bus.pending), 32'b0101);
        cyc(0, 4'h0, 1, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 1, 0, 4'h0);
        cyc(0, 4'h0, 0, 0, 0, 4'h0);
        chk("next_id", 32'(bus.active_id), 32'd0);
        cyc(0, 4'h0, 1, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 1, 0, 4'h0);

        // Masked capture, released by a mask write.
        cyc(0, 4'h0, 0, 0, 1, 4'h0);
        cyc(0, 4'b0010, 0, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 0, 0, 4'h0);
        chk("masked_pend", 32'(bus.pending), 32'b0010);
        chk("masked_irq", 32'(bus.interrupt), 32'd0);
        cyc(0, 4'h0, 0, 0, 1, 4'b0010);
        cyc(0, 4'h0, 0, 0, 0, 4'h0);
        chk("unmask_irq", 32'(bus.interrupt), 32'd1);
        cyc(0, 4'h0, 1, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 1, 0, 4'h0);

        // Reset while in service.
        cyc(0, 4'h0, 0, 0, 1, 4'hF);
        cyc(0, 4'b0001, 0, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 0, 0, 4'h0);
        cyc(0, 4'b0100, 1, 0, 0, 4'h0);
        cyc(1, 4'b0100, 0, 0, 0, 4'h0);
        chk("svc_rst_busy", 32'(bus.busy), 32'd0);
        chk("svc_rst_pend", 32'(bus.pending), 32'd0);

        // irq[3] held five cycles through a full ack/done sequence.
        cyc(0, 4'h0, 0, 0, 1, 4'b1000);
        cyc(0, 4'b1000, 0, 0, 0, 4'h0);
        cyc(0, 4'b1000, 0, 0, 0, 4'h0);
        cyc(0, 4'b1000, 1, 0, 0, 4'h0);
        cyc(0, 4'b1000, 0, 1, 0, 4'h0);
        cyc(0, 4'b1000, 0, 0, 0, 4'h0);
`ifdef IRQ_EDGE_DETECT_EN
        chk("held_once", 32'(bus.interrupt), 32'd0);
`else
        chk("held_again", 32'(bus.interrupt), 32'd1);
`endif
        cyc(0, 4'h0, 1, 0, 0, 4'h0);
        cyc(0, 4'h0, 0, 1, 0, 4'h0);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 15) == 0),
                4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 32'h000000C0, is the handler address for source 0.
REQ-002 Parameter VEC_STRIDE, default 32'h00000010, is the byte spacing between consecutive handler addresses.
REQ-003 The block SHALL use one clock, clk, and a synchronous active-high reset, reset.
REQ-004 clk  input  1  rising-edge system clock, shared with the processor.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 irq  input  4  external interrupt request lines; irq[0] has the highest priority.
REQ-007 int_ack  input  1  one-cycle pulse from the processor: interrupt taken, EPC written.
REQ-008 int_done  input  1  one-cycle pulse from the processor: handler returned.
REQ-009 mask_we  input  1  mask write strobe.
REQ-010 mask_wd  input  4  mask write data; 1 enables the source.
REQ-011 interrupt  output  1  request to the processor.
REQ-012 vector  output  32  handler address for active_id.
REQ-013 active_id  output  2  source currently requested or in service.
REQ-014 pending  output  4  captured, unserviced requests.
REQ-015 mask  output  4  current enable mask.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Capture: pending[i] SHALL set at a clk edge when the capture condition for irq[i] holds (see REQ-030/031); masked sources still capture.
REQ-018 Clear: at the clk edge where int_ack=1 in state REQ, pending[active_id] SHALL clear; if the same bit also meets the set condition on that edge, set wins.
REQ-019 Mask: when mask_we=1, mask SHALL load mask_wd at the clk edge.
REQ-020 Eligible set = pending & mask; the winner SHALL be the lowest eligible index.
REQ-021 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-022 IDLE->REQ: if the eligible set is non-zero at the edge, latch the winner into active_id. Otherwise stay in IDLE.
REQ-023 REQ: interrupt=1. On int_ack=1 -> SERVICE. active_id SHALL stay frozen; neither a higher-priority arrival nor a mask change withdraws or changes the request.
REQ-024 SERVICE: interrupt=0. On int_done=1 -> IDLE. No nesting.
REQ-025 int_ack outside REQ and int_done outside SERVICE SHALL be ignored.
REQ-026 vector SHALL equal VEC_BASE + active_id*VEC_STRIDE (32-bit, wrap on overflow), combinational from the active_id register.
REQ-027 Latency: irq[i] captured at edge N with mask[i]=1 in IDLE -> interrupt high after edge N+1.
REQ-028 After int_done, if another source is eligible, the FSM SHALL pass through one IDLE cycle before re-entering REQ.

Reset
REQ-029 While reset=1 at a clk edge, regardless of state: FSM=IDLE, pending=0, mask=4'b0000, active_id=0, irq edge history=0, interrupt=0, busy=0, vector=VEC_BASE. reset has priority over all other inputs.

Configuration
REQ-030 With IRQ_EDGE_DETECT_EN defined: capture is edge-triggered. The block SHALL register irq each cycle, and pending[i] sets only when irq[i]=1 and the registered irq[i]=0. A held line raises one request.
REQ-031 Without IRQ_EDGE_DETECT_EN: capture is level-triggered. pending[i] sets on every edge where irq[i]=1, and no irq history register exists.

Verification
REQ-032 Reset, mask_wd=4'b1111 written, irq=4'b0100 pulsed at edge N -> interrupt=1 after N+1, active_id=2, vector=32'h000000E0.
REQ-033 irq=4'b1010 asserted together, mask=4'b1111 -> active_id=1, vector=32'h000000D0. After int_ack and int_done, the next request has active_id=3, vector=32'h000000F0.
REQ-034 In REQ with active_id=2, irq[0] rises -> active_id stays 2, pending[0]=1. After int_done and one IDLE cycle, active_id=0.
REQ-035 mask=4'b0000, irq[1] pulsed -> pending=4'b0010, interrupt=0. Then mask_wd=4'b0010 is written -> interrupt=1 two edges later.
REQ-036 reset=1 asserted in SERVICE -> after that edge: state IDLE, busy=0, pending=0, mask=0, interrupt=0.
REQ-037 irq[3] held high for 5 cycles with mask=4'b1000 and a full ack/done sequence -> one request with IRQ_EDGE_DETECT_EN defined. Without it, pending[3] re-sets after ack and a second request follows.
